// File: rtl/ctrl_raiz_if.sv
// Start/operand and result bundle between the operation decoder, the
// square-root sequencer and the display mux.
interface ctrl_raiz_if #(
    parameter int N = 16
) ();
    logic             init;
    logic [N-1:0]     RAD;
    logic [N/2-1:0]   RAIZ;
    logic [N/2:0]     RESIDUO;
    logic             busy;
    logic             done;

    modport master (
        output init, RAD,
        input  RAIZ, RESIDUO, busy, done
    );

    modport slave (
        input  init, RAD,
        output RAIZ, RESIDUO, busy, done
    );
endinterface

// File: rtl/ctrl_raiz.sv
// Sequencer for the digit-by-digit restoring integer square root:
// two radicand bits per SHIFT/TEST pair, N/2 pairs per operation.
module ctrl_raiz #(
    parameter int N = 16
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_raiz_if.slave  bus
);
    localparam int AW = 16;
    localparam int RW = N / 2;
    localparam int CW = $clog2(RW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TEST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    r_q, r_d;
    logic [AW-1:0]   a_q, a_d;
    logic [RW-1:0]   tmp_q, tmp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   raiz_q, raiz_d;
    logic [RW:0]     res_q, res_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [AW-1:0]   trial_s;
    logic [AW-1:0]   diff_s;
    logic [CW-1:0]   cnt_dec_s;

    // Trial subtrahend (4*TMP+1); the remainder bound keeps diff's MSB a true sign.
    assign trial_s   = AW'({tmp_q, 2'b01});
    assign diff_s    = a_q - trial_s;
    assign cnt_dec_s = cnt_q - CW'(1);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        a_d     = a_q;
        tmp_d   = tmp_q;
        cnt_d   = cnt_q;
        raiz_d  = raiz_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.init) begin
                    r_d     = bus.RAD;
                    a_d     = {AW{1'b0}};
                    tmp_d   = {RW{1'b0}};
                    cnt_d   = CW'(RW);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = {a_q[AW-3:0], r_q[N-1:N-2]};
                r_d     = {r_q[N-3:0], 2'b00};
                state_d = TEST;
            end
            TEST: begin
                if (diff_s[AW-1] == 1'b0) begin
                    a_d   = diff_s;
                    tmp_d = {tmp_q[RW-2:0], 1'b1};
                end else begin
                    a_d   = a_q;
                    tmp_d = {tmp_q[RW-2:0], 1'b0};
                end
                cnt_d = cnt_dec_s;
                if (cnt_dec_s == {CW{1'b0}}) begin
                    raiz_d  = tmp_d;
                    res_d   = a_d[RW:0];
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT) || (state_d == TEST);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= {N{1'b0}};
            a_q     <= {AW{1'b0}};
            tmp_q   <= {RW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            raiz_q  <= {RW{1'b0}};
            res_q   <= {(RW+1){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            a_q     <= a_d;
            tmp_q   <= tmp_d;
            cnt_q   <= cnt_d;
            raiz_q  <= raiz_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.RAIZ    = raiz_q;
    assign bus.RESIDUO = res_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_ctrl_raiz.sv
// Scoreboard bench for ctrl_raiz: expected results queued at stimulus,
// checked by an independent monitor on every done pulse.
module tb_ctrl_raiz;
    typedef struct {
        int rad;
        int raiz;
        int res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ctrl_raiz_if #(.N(16)) bus ();

    ctrl_raiz #(.N(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            int   rz;
            int   rs;
            done_cnt++;
            rz = int'(bus.RAIZ);
            rs = int'(bus.RESIDUO);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("raiz", rz, e.raiz);
                check("residuo", rs, e.res);
                check("sum", rz * rz + rs, e.rad);
                check("res_bound", int'(rs <= 2 * rz), 1);
            end
        end
    end

    // Issue one request and measure done latency / busy width (negedge count)
    task automatic run_one(input int rad, input int er, input int es);
        int lat = 0;
        int bc  = 0;
        exp_q.push_back('{rad, er, es});
        bus.RAD  = 16'(rad);
        bus.init = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.init = 1'b0;
            if (bus.busy) bc++;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 17);
        check("busy_cycles", bc, 16);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int t[3];
        int nd;
        bus.init = 1'b0;
        bus.RAD  = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_raiz", int'(bus.RAIZ), 0);
        check("rst_residuo", int'(bus.RESIDUO), 0);
        rst = 1'b0;
        @(negedge clk);

        run_one(0, 0, 0);
        run_one(144, 12, 0);
        run_one(200, 14, 4);
        run_one(65535, 255, 510);
        run_one(1, 1, 0);

        // Second request while busy must be ignored
        d0 = done_cnt;
        exp_q.push_back('{144, 12, 0});
        bus.RAD  = 16'd144;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        repeat (4) @(negedge clk);
        bus.RAD  = 16'd9999;
        bus.init = 1'b1;
        repeat (3) @(negedge clk);
        bus.init = 1'b0;
        repeat (30) @(negedge clk);
        check("overlap_done_count", done_cnt - d0, 1);

        // Reset mid-computation aborts and clears results
        d0 = done_cnt;
        bus.RAD  = 16'd65535;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_raiz", int'(bus.RAIZ), 0);
        check("abort_residuo", int'(bus.RESIDUO), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        run_one(50, 7, 1);

        // init held high: back-to-back runs 18 cycles apart
        for (int i = 0; i < 3; i++) exp_q.push_back('{625, 25, 0});
        bus.RAD  = 16'd625;
        bus.init = 1'b1;
        nd = 0;
        for (int i = 1; i <= 80 && nd < 3; i++) begin
            @(negedge clk);
            if (bus.done) begin
                t[nd] = i;
                nd++;
                if (nd == 3) bus.init = 1'b0;
            end
            if (nd == 1 && i == t[0] + 1) begin
                check("idle_gap_busy", int'(bus.busy), 0);
                check("idle_gap_done", int'(bus.done), 0);
            end
        end
        check("held_done_count", nd, 3);
        check("held_period1", t[1] - t[0], 18);
        check("held_period2", t[2] - t[1], 18);
        repeat (25) @(negedge clk);

        // Random sweep against the reference model
        for (int i = 0; i < 1000; i++) begin
            int v = int'($urandom_range(0, 65535));
            int r = isqrt(v);
            run_one(v, r, v - r * r);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
